// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the issue block, the decoder and the ALU.
package rv32i_pkg;

  localparam int XLEN_DEF = 32;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU function codes, {funct7b5, funct3} for register ops
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // How the branch outcome is derived from the ALU result
  typedef enum logic [2:0] {
    TSEL_NONE,
    TSEL_ZERO,
    TSEL_NONZERO,
    TSEL_BIT0,
    TSEL_NBIT0
  } taken_sel_e;

  // One writeback/branch entry held in the skid buffer
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        branch;
    logic        taken;
    logic        illegal;
  } wb_entry_t;

  // The ALU shifts by its whole second operand, so shift amounts are trimmed
  function automatic logic is_shift(input logic [3:0] func);
    return (func == ALU_SLL) || (func == ALU_SRL) || (func == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational mapping of a decoded RV32I instruction onto ALU operands,
// function code and writeback/branch attributes.
module alu_op_decode
  import rv32i_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic [4:0]  rd,
  output logic [31:0] alu_in0,
  output logic [31:0] alu_in1,
  output logic [3:0]  alu_func,
  output logic        is_branch,
  output logic        illegal,
  output logic        we,
  output taken_sel_e  taken_sel
);

  // Opcode/funct decode; illegal encodings collapse to add 0+0 and are
  // never reported as branches.
  always_comb begin
    alu_in0   = '0;
    alu_in1   = '0;
    alu_func  = ALU_ADD;
    is_branch = 1'b0;
    illegal   = 1'b0;
    taken_sel = TSEL_NONE;

    case (opcode)
      OPC_OP: begin
        alu_in0  = rs1;
        alu_in1  = rs2;
        alu_func = {funct7b5, funct3};
        if (funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        alu_in0  = rs1;
        alu_in1  = imm;
        alu_func = {((funct3 == 3'b101) ? funct7b5 : 1'b0), funct3};
      end
      OPC_LUI: begin
        alu_in0 = '0;
        alu_in1 = imm;
      end
      OPC_AUIPC: begin
        alu_in0 = pc;
        alu_in1 = imm;
      end
      OPC_BRANCH: begin
        alu_in0   = rs1;
        alu_in1   = rs2;
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ: begin
            alu_func  = ALU_SUB;
            taken_sel = TSEL_ZERO;
          end
          F3_BNE: begin
            alu_func  = ALU_SUB;
            taken_sel = TSEL_NONZERO;
          end
          F3_BLT, F3_BGE: begin
            alu_func  = ALU_SLT;
            taken_sel = funct3[0] ? TSEL_NBIT0 : TSEL_BIT0;
          end
          F3_BLTU, F3_BGEU: begin
            alu_func  = ALU_SLTU;
            taken_sel = funct3[0] ? TSEL_NBIT0 : TSEL_BIT0;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      alu_in0   = '0;
      alu_in1   = '0;
      alu_func  = ALU_ADD;
      is_branch = 1'b0;
      taken_sel = TSEL_NONE;
    end else if (is_shift(alu_func)) begin
      alu_in1 = {27'b0, alu_in1[4:0]};
    end
  end

  // Register write only for legal non-branch results to a real register
  always_comb begin
    we = !illegal && !is_branch && (rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue block: drives the external ALU from the incoming
// instruction and registers its outcome into a 2-entry skid buffer.
//
// state    | meaning
// ST_EMPTY | no entry held, out_valid low
// ST_ONE   | head entry valid, tail free
// ST_TWO   | head and tail valid, upstream stalled
module alu_issue
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] alu_in0,
  output logic [XLEN-1:0] alu_in1,
  output logic [3:0]      alu_func,
  input  logic [XLEN-1:0] alu_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_branch,
  output logic            out_taken,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } occ_e;

  occ_e       state_q, state_d;
  wb_entry_t  head_q, head_d;
  wb_entry_t  tail_q, tail_d;
  logic       in_ready_q, in_ready_d;

  logic       dec_branch;
  logic       dec_illegal;
  logic       dec_we;
  taken_sel_e dec_tsel;
  logic       taken_c;
  wb_entry_t  new_entry;
  logic       push;
  logic       pop;

  alu_op_decode u_dec (
    .opcode    (in_opcode),
    .funct3    (in_funct3),
    .funct7b5  (in_funct7b5),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .imm       (in_imm),
    .pc        (in_pc),
    .rd        (in_rd),
    .alu_in0   (alu_in0),
    .alu_in1   (alu_in1),
    .alu_func  (alu_func),
    .is_branch (dec_branch),
    .illegal   (dec_illegal),
    .we        (dec_we),
    .taken_sel (dec_tsel)
  );

  // Branch outcome from the returned ALU result
  always_comb begin
    taken_c = 1'b0;
    case (dec_tsel)
      TSEL_ZERO:    taken_c = (alu_out == '0);
      TSEL_NONZERO: taken_c = (alu_out != '0);
      TSEL_BIT0:    taken_c = alu_out[0];
      TSEL_NBIT0:   taken_c = !alu_out[0];
      default:      taken_c = 1'b0;
    endcase
  end

  // Entry captured on a push edge
  always_comb begin
    new_entry.result  = dec_illegal ? '0 : alu_out;
    new_entry.rd      = in_rd;
    new_entry.we      = dec_we;
    new_entry.branch  = dec_branch;
    new_entry.taken   = taken_c;
    new_entry.illegal = dec_illegal;
  end

  assign push = in_valid && in_ready_q;
  assign pop  = (state_q != ST_EMPTY) && out_ready;

  // Occupancy next-state and entry movement; in TWO no push can occur
  // because in_ready was already low.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO);
  end

  // State and buffer registers; reset flushes both entries
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_result  = head_q.result;
  assign out_rd      = head_q.rd;
  assign out_we      = head_q.we;
  assign out_branch  = head_q.branch;
  assign out_taken   = head_q.taken;
  assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU on the alu_* port, directed cases
// and a randomized run scored against an instruction-level model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [4:0]  in_rd;
  logic [31:0] alu_in0, alu_in1;
  logic [3:0]  alu_func;
  logic [31:0] alu_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we, out_branch, out_taken, out_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic last_push = 1'b0;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        tk;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_pc       (in_pc),
    .in_rd       (in_rd),
    .alu_in0     (alu_in0),
    .alu_in1     (alu_in1),
    .alu_func    (alu_func),
    .alu_out     (alu_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_branch  (out_branch),
    .out_taken   (out_taken),
    .out_illegal (out_illegal)
  );

  // Behavioural RV32I ALU, shifting by its full second operand
  always_comb begin
    case (alu_func)
      4'b0000: alu_out = alu_in0 + alu_in1;
      4'b1000: alu_out = alu_in0 - alu_in1;
      4'b0001: alu_out = alu_in0 << alu_in1;
      4'b0010: alu_out = ($signed(alu_in0) < $signed(alu_in1)) ? 32'd1 : 32'd0;
      4'b0011: alu_out = (alu_in0 < alu_in1) ? 32'd1 : 32'd0;
      4'b0100: alu_out = alu_in0 ^ alu_in1;
      4'b0101: alu_out = alu_in0 >> alu_in1;
      4'b1101: alu_out = $signed(alu_in0) >>> alu_in1;
      4'b0110: alu_out = alu_in0 | alu_in1;
      4'b0111: alu_out = alu_in0 & alu_in1;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: what the instruction means, not how it maps
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [4:0] rd);
    exp_t e;
    logic [31:0] b;
    e.result = 32'd0;
    e.rd     = rd;
    e.br     = 1'b0;
    e.tk     = 1'b0;
    e.ill    = 1'b0;
    if (op == 7'b0110011 || op == 7'b0010011) begin
      b = (op == 7'b0110011) ? rs2 : imm;
      if (op == 7'b0110011 && f7 && f3 != 3'd0 && f3 != 3'd5) begin
        e.ill = 1'b1;
      end else begin
        case (f3)
          3'd0: e.result = (op == 7'b0110011 && f7) ? a - b : a + b;
          3'd1: e.result = a << b[4:0];
          3'd2: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: e.result = (a < b) ? 32'd1 : 32'd0;
          3'd4: e.result = a ^ b;
          3'd5: begin
            if (f7) e.result = $signed(a) >>> b[4:0];
            else    e.result = a >> b[4:0];
          end
          3'd6: e.result = a | b;
          default: e.result = a & b;
        endcase
      end
    end else if (op == 7'b0110111) begin
      e.result = imm;
    end else if (op == 7'b0010111) begin
      e.result = pc + imm;
    end else if (op == 7'b1100011) begin
      e.br = 1'b1;
      case (f3)
        3'd0: begin e.result = a - rs2; e.tk = (a == rs2); end
        3'd1: begin e.result = a - rs2; e.tk = (a != rs2); end
        3'd4: begin e.tk = ($signed(a) < $signed(rs2));  e.result = {31'd0, e.tk}; end
        3'd5: begin e.tk = !($signed(a) < $signed(rs2)); e.result = {31'd0, !e.tk}; end
        3'd6: begin e.tk = (a < rs2);  e.result = {31'd0, e.tk}; end
        3'd7: begin e.tk = !(a < rs2); e.result = {31'd0, !e.tk}; end
        default: begin e.ill = 1'b1; e.br = 1'b0; end
      endcase
    end else begin
      e.ill = 1'b1;
    end
    e.we = !e.ill && !e.br && (rd != 5'd0);
    return e;
  endfunction

  // One clock: score handshakes at negedge, then return just after posedge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_push = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          n_pops++;
          chk("q_result",  out_result,  e.result);
          chk("q_rd",      out_rd,      e.rd);
          chk("q_we",      out_we,      e.we);
          chk("q_branch",  out_branch,  e.br);
          chk("q_taken",   out_taken,   e.tk);
          chk("q_illegal", out_illegal, e.ill);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, in_pc, in_rd));
        last_push = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_rs1      = a;
    in_rs2      = b;
    in_imm      = imm;
    in_pc       = pc;
    in_rd       = rd;
  endtask

  task automatic rand_instr();
    logic [31:0] r;
    int k;
    k = $urandom_range(0, 9);
    r = $urandom;
    in_funct3   = 3'($urandom_range(0, 7));
    in_funct7b5 = ($urandom_range(0, 3) == 0);
    in_rs1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    in_rs2      = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
    in_imm      = {{20{r[11]}}, r[11:0]};
    in_pc       = {$urandom} & 32'hFFFF_FFFC;
    in_rd       = 5'($urandom_range(0, 31));
    if (k <= 2)      in_opcode = 7'b0110011;
    else if (k <= 4) in_opcode = 7'b0010011;
    else if (k == 5) begin in_opcode = 7'b0110111; in_imm = {r[31:12], 12'd0}; end
    else if (k == 6) begin in_opcode = 7'b0010111; in_imm = {r[31:12], 12'd0}; end
    else if (k <= 8) in_opcode = 7'b1100011;
    else             in_opcode = 7'($urandom);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_result", out_result, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1'b1);

    // ADD, latency one cycle
    out_ready = 1'b1;
    drive(7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
    #1 chk("add_func", alu_func, 4'b0000);
    tick();
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1'b1);
    chk("add_result", out_result, 32'd12);
    chk("add_we", out_we, 1'b1);
    tick();

    // SRA / SRAI with shift masking
    drive(7'b0110011, 3'd5, 1'b1, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 5'd4);
    #1 chk("sra_in1", alu_in1, 32'd4);
    chk("sra_func", alu_func, 4'b1101);
    tick();
    chk("sra_result", out_result, 32'hF800_0000);
    drive(7'b0010011, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'h404, 32'd0, 5'd5);
    #1 chk("srai_in1", alu_in1, 32'd4);
    chk("srai_func", alu_func, 4'b1101);
    tick();
    chk("srai_result", out_result, 32'hF800_0000);

    // Branches
    drive(7'b1100011, 3'd6, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd7);
    #1 chk("bltu_func", alu_func, 4'b0011);
    tick();
    chk("bltu_taken", out_taken, 1'b1);
    chk("bltu_we", out_we, 1'b0);
    chk("bltu_branch", out_branch, 1'b1);
    drive(7'b1100011, 3'd5, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 5'd7);
    tick();
    chk("bge_taken", out_taken, 1'b0);

    // Illegal encodings and rd=0
    drive(7'b0000000, 3'd0, 1'b0, 32'd9, 32'd9, 32'd9, 32'd9, 5'd8);
    #1 chk("ill_func", alu_func, 4'b0000);
    chk("ill_in0", alu_in0, 32'd0);
    chk("ill_in1", alu_in1, 32'd0);
    tick();
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_result", out_result, 32'd0);
    chk("ill_we", out_we, 1'b0);
    drive(7'b0110011, 3'd4, 1'b1, 32'd3, 32'd6, 32'd0, 32'd0, 5'd8);
    tick();
    chk("op_f7_ill", out_illegal, 1'b1);
    drive(7'b0110011, 3'd0, 1'b0, 32'd3, 32'd6, 32'd0, 32'd0, 5'd0);
    tick();
    chk("rd0_we", out_we, 1'b0);
    chk("rd0_result", out_result, 32'd9);
    in_valid = 1'b0;
    tick();
    chk("idle_valid", out_valid, 1'b0);

    // Backpressure: two accepts then stall, drain in order
    out_ready = 1'b0;
    drive(7'b0110011, 3'd0, 1'b0, 32'd10, 32'd1, 32'd0, 32'd0, 5'd1);
    tick();
    chk("bp_rdy1", in_ready, 1'b1);
    drive(7'b0110011, 3'd0, 1'b0, 32'd20, 32'd2, 32'd0, 32'd0, 5'd2);
    tick();
    chk("bp_rdy2", in_ready, 1'b0);
    chk("bp_head", out_result, 32'd11);
    drive(7'b0110011, 3'd0, 1'b0, 32'd30, 32'd3, 32'd0, 32'd0, 5'd3);
    tick();
    chk("bp_stall_rdy", in_ready, 1'b0);
    chk("bp_stall_head", out_result, 32'd11);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1", out_result, 32'd22);
    chk("bp_rdy_back", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_pop2", out_result, 32'd33);
    tick();
    chk("bp_empty", out_valid, 1'b0);

    // Reset with two entries held
    out_ready = 1'b0;
    drive(7'b0110011, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1);
    tick();
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_rdy", in_ready, 1'b0);
    chk("mid_rst_result", out_result, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_rdy", in_ready, 1'b1);
    chk("mid_rel_valid", out_valid, 1'b0);

    // Randomized traffic with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !last_push)) begin
        rand_instr();
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if (i == 1500) begin
        rst_n = 1'b0;
        tick();
        chk("rnd_rst_valid", out_valid, 1'b0);
        rst_n = 1'b1;
      end
      #1 if (in_valid && in_opcode == 7'b0110011 && in_funct3 == 3'd1 && !in_funct7b5)
        chk("rnd_sll_mask", alu_in1, {27'd0, in_rs2[4:0]});
      tick();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drain_valid", out_valid, 1'b0);
    chk("pops_seen", (n_pops > 500) ? 32'd1 : 32'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
